and3_bist_ctrl: RTL
===================

// Module: and3_bist_ctrl
// PURPOSE
//  Built-in self-test sequencer for the 3-input AND gate (generalised to N inputs).
//  On a start pulse it walks all 2^N input combinations in ascending binary order.
//  It waits a programmable settle time per vector, samples the gate output and
//  compares it to the expected AND of the vector. Reports pass/fail, error count
//  and the first failing vector. Sits between system control and the gate under test.
// PARAMETERS
//  N_IN        3   number of gate inputs / width of vec (legal 1..8)
//  SETTLE_CYC  2   cycles each vector is held before sampling (legal 1..255)
// PORTS
//  clk            in   1       single clock, all logic on rising edge
//  rst            in   1       synchronous, active-high reset
//  start          in   1       1-cycle request to run a full sweep
//  dut_s          in   1       gate output under test
//  vec            out  N_IN    input vector driven to gate (vec[N_IN-1]=a ... vec[0]=c)
//  busy           out  1       high from first DRIVE cycle through DONE cycle
//  done           out  1       1-cycle pulse at end of sweep
//  pass           out  1       1 = last sweep had zero mismatches; held until next start
//  err_cnt        out  N_IN+1  mismatch count of current/last sweep
//  first_err_vec  out  N_IN    vec of first mismatch; valid when err_cnt != 0
// BEHAVIOUR
//  - Reset (clk edge with rst=1): state=IDLE; vec=0, busy=0, done=0, pass=0,
//    err_cnt=0, first_err_vec=0. rst overrides start and any state (abort mid-sweep).
//  - FSM: IDLE -> DRIVE -> CHECK -> (DRIVE | DONE) -> IDLE.
//  - IDLE: start=1 sampled -> vec=0, err_cnt=0, pass=0, first_err_vec=0,
//    settle counter=0, go to DRIVE. start=0 -> stay.
//  - DRIVE: hold vec for SETTLE_CYC cycles (counter 0..SETTLE_CYC-1), then CHECK.
//  - CHECK (1 cycle): expected = &vec. If dut_s != expected: err_cnt+=1; if
//    err_cnt was 0, first_err_vec=vec. If vec == 2^N_IN-1 -> DONE, else vec+=1 -> DRIVE.
//  - DONE (1 cycle): done=1, pass=(err_cnt==0), vec holds last value, then IDLE.
//  - busy=1 in DRIVE, CHECK, DONE; 0 in IDLE.
//  - Latency: start sampled at edge 0 -> done high in cycle 2^N_IN*(SETTLE_CYC+1)+1.
//    With the defaults (N_IN=3, SETTLE_CYC=2) this is cycle 25.
//  - start while busy: ignored, no restart, no queueing.
//  - start on the same edge the FSM returns from DONE to IDLE: ignored; a new
//    start is needed with the FSM already in IDLE.
//  - err_cnt saturates-free: its max is 2^N_IN, which fits in N_IN+1 bits.
//  - vec increments without wrap; the sweep terminates at the all-ones vector.
//  - dut_s is sampled only in CHECK; X/changes in other states are ignored.
// CONFIGURATION
//  AND3_BIST_STOP_ON_FAIL_EN
//   defined: the first mismatch in CHECK goes straight to DONE (err_cnt=1,
//            first_err_vec=failing vec, vec frozen at failing value).
//   undefined: the full sweep always completes and all mismatches are counted.
// TESTING (N_IN=3, SETTLE_CYC=2 unless stated)
//  1 good gate (dut_s=&vec), start pulse -> vec 0..7 each held 3 cycles;
//    done in cycle 25; pass=1, err_cnt=0, busy low from cycle 26.
//  2 stuck-at-0 dut_s -> done in cycle 25; pass=0, err_cnt=1, first_err_vec=3'b111.
//  3 stuck-at-1 dut_s -> pass=0, err_cnt=7, first_err_vec=3'b000.
//  4 AND3_BIST_STOP_ON_FAIL_EN defined, stuck-at-1 -> done in cycle 4;
//    err_cnt=1, first_err_vec=0, vec=0.
//  5 rst=1 at cycle 10 of a sweep -> next cycle all outputs = reset values and
//    state=IDLE; a new start then gives a full 25-cycle sweep.
//  6 start re-pulsed at cycles 5 and 25 -> ignored; exactly one done pulse;
//    start in cycle 27 launches a second sweep, and err_cnt/pass reset on it.

Source files
------------

// File: rtl/and3_bist_ctrl.sv
// -----------------------------------------------------------------------------
// and3_bist_ctrl
//   Built-in self-test sequencer for an N-input AND gate. A start pulse
//   launches a sweep over all 2^N_IN input vectors in ascending order. Each
//   vector is held for SETTLE_CYC cycles and then the gate output is compared
//   with the expected AND. The block reports pass/fail, a mismatch count and
//   the first failing vector.
//
// Parameters
//   N_IN        number of gate inputs (1..8)
//   SETTLE_CYC  cycles each vector is held before sampling (1..255)
//
// Configuration macro
//   AND3_BIST_STOP_ON_FAIL_EN  defined: end the sweep at the first mismatch
//                              undefined: always run the full sweep
//
// Ports
//   i_clk             clock, all logic on rising edge
//   i_rst             synchronous active-high reset
//   i_start           1-cycle sweep request (ignored while busy)
//   i_dut_s           gate output under test
//   o_vec             vector driven to the gate (o_vec[N_IN-1]=a ... [0]=c)
//   o_busy            high from the first DRIVE cycle through the DONE cycle
//   o_done            1-cycle pulse at end of sweep
//   o_pass            last sweep had zero mismatches (held until next start)
//   o_err_cnt         mismatch count of current/last sweep
//   o_first_err_vec   vector of the first mismatch (valid when o_err_cnt != 0)
// -----------------------------------------------------------------------------
module and3_bist_ctrl #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_dut_s,
  output logic [N_IN-1:0] o_vec,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic [N_IN-1:0] o_first_err_vec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_settle;
  logic [N_IN-1:0] r_vec;
  logic [N_IN:0]   r_err_cnt;
  logic [N_IN-1:0] r_first_err_vec;
  logic            r_pass;
  logic            r_busy;
  logic            r_done;

  logic            w_mismatch;
  logic            w_last_vec;
  logic            w_stop;
  logic [N_IN:0]   w_err_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  // Compare the gate against the reference AND; only meaningful in CHECK.
  assign w_mismatch = (i_dut_s != (&r_vec));
  assign w_last_vec = (r_vec == VEC_LAST);
  assign w_err_nxt  = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

`ifdef AND3_BIST_STOP_ON_FAIL_EN
  // A mismatch ends the sweep early with the failing vector frozen on o_vec.
  assign w_stop = w_last_vec | w_mismatch;
`else
  assign w_stop = w_last_vec;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_DRIVE;
        else         w_state_nxt = S_IDLE;
      end
      S_DRIVE: begin
        if (r_settle == SETTLE_LAST) w_state_nxt = S_CHECK;
        else                         w_state_nxt = S_DRIVE;
      end
      S_CHECK: begin
        if (w_stop) w_state_nxt = S_DONE;
        else        w_state_nxt = S_DRIVE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode, taken from the next state so busy/done can be registered
  // and still line up with the state they describe.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Sweep datapath: vector, settle counter, error bookkeeping and flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec           <= '0;
      r_settle        <= 8'd0;
      r_err_cnt       <= '0;
      r_first_err_vec <= '0;
      r_pass          <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_vec           <= '0;
            r_settle        <= 8'd0;
            r_err_cnt       <= '0;
            r_first_err_vec <= '0;
            r_pass          <= 1'b0;
          end
        end
        S_DRIVE: begin
          // Counter is cleared on its last value so the next vector starts at 0.
          if (r_settle == SETTLE_LAST) r_settle <= 8'd0;
          else                         r_settle <= r_settle + 8'd1;
        end
        S_CHECK: begin
          r_err_cnt <= w_err_nxt;
          if (w_mismatch && (r_err_cnt == '0)) begin
            r_first_err_vec <= r_vec;
          end
          // pass is settled together with the final count so it is valid with done.
          if (w_stop) r_pass <= (w_err_nxt == '0);
          else        r_vec  <= r_vec + {{(N_IN-1){1'b0}}, 1'b1};
        end
        S_DONE: begin
          r_settle <= 8'd0;
        end
        default: begin
          r_settle <= 8'd0;
        end
      endcase
    end
  end

  assign o_vec           = r_vec;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_vec = r_first_err_vec;

endmodule
